// File: rtl/multi_cycle_sequencer.sv
// Stage sequencer for the multi-cycle RV32I core: per-opcode stage skipping, halt/resume, watchdog, fault capture.
// Latency: enables are combinational from the registered stage; 3 (branch) to 5+ (load) cycles per instruction.
// Backpressure: mem_ready low holds FETCH/MEMORY; a stall longer than MEM_TIMEOUT cycles faults.
module multi_cycle_sequencer #(
    parameter int STAGE_WIDTH      = 3,
    parameter int RETIRE_CNT_WIDTH = 32,
    parameter int MEM_TIMEOUT      = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [6:0]                  opcode,
    input  logic                        mem_ready,
    input  logic                        halt_req,
    input  logic                        resume,
    output logic [STAGE_WIDTH-1:0]      stage,
    output logic                        ir_en,
    output logic                        pc_en,
    output logic                        rf_we,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic                        retire,
    output logic [RETIRE_CNT_WIDTH-1:0] retired_count,
    output logic                        halted,
    output logic                        fault,
    output logic [1:0]                  fault_cause
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

    localparam logic [1:0] CAUSE_TIMEOUT = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b10;

    localparam int WD_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd6,
        ST_FAULT     = 3'd7
    } state_t;

    state_t                      state;
    state_t                      state_nxt;
    logic                        halt_pending;
    logic [WD_W-1:0]             wd_cnt;
    logic [1:0]                  cause_q;
    logic [1:0]                  cause_nxt;
    logic [RETIRE_CNT_WIDTH-1:0] count_q;

    logic ir_en_c, pc_en_c, rf_we_c, mem_req_c, mem_we_c, retire_c;
    logic is_load, is_store, is_branch, is_legal;
    logic wd_expire;
    logic mem_wait;

    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign is_branch = (opcode == OPC_BRANCH);
    assign is_legal  = is_load || is_store || is_branch ||
                       (opcode == OPC_JAL)   || (opcode == OPC_JALR)  ||
                       (opcode == OPC_LUI)   || (opcode == OPC_AUIPC) ||
                       (opcode == OPC_OP)    || (opcode == OPC_OPIMM);

    assign mem_wait  = ((state == ST_FETCH) || (state == ST_MEMORY)) && !mem_ready;
    assign wd_expire = (MEM_TIMEOUT > 0) && mem_wait && (wd_cnt == WD_W'(MEM_TIMEOUT));

    always_comb begin
        state_nxt = state;
        cause_nxt = cause_q;
        ir_en_c   = 1'b0;
        pc_en_c   = 1'b0;
        rf_we_c   = 1'b0;
        mem_req_c = 1'b0;
        mem_we_c  = 1'b0;
        retire_c  = 1'b0;
        case (state)
            ST_FETCH: begin
                mem_req_c = 1'b1;
                if (mem_ready) begin
                    ir_en_c   = 1'b1;
                    state_nxt = ST_DECODE;
                end else if (wd_expire) begin
                    state_nxt = ST_FAULT;
                    cause_nxt = CAUSE_TIMEOUT;
                end
            end
            ST_DECODE: begin
                if (is_legal) begin
                    state_nxt = ST_EXECUTE;
                end else begin
                    state_nxt = ST_FAULT;
                    cause_nxt = CAUSE_ILLEGAL;
                end
            end
            ST_EXECUTE: begin
                if (is_load || is_store) begin
                    state_nxt = ST_MEMORY;
                end else if (is_branch) begin
                    pc_en_c  = 1'b1;
                    retire_c = 1'b1;
                end else begin
                    state_nxt = ST_WRITEBACK;
                end
            end
            ST_MEMORY: begin
                mem_req_c = 1'b1;
                mem_we_c  = is_store;
                if (mem_ready) begin
                    if (is_store) begin
                        pc_en_c  = 1'b1;
                        retire_c = 1'b1;
                    end else begin
                        state_nxt = ST_WRITEBACK;
                    end
                end else if (wd_expire) begin
                    state_nxt = ST_FAULT;
                    cause_nxt = CAUSE_TIMEOUT;
                end
            end
            ST_WRITEBACK: begin
                rf_we_c  = 1'b1;
                pc_en_c  = 1'b1;
                retire_c = 1'b1;
            end
            ST_HALT: begin
                if (resume && !halt_req) state_nxt = ST_FETCH;
            end
            ST_FAULT: begin
                state_nxt = ST_FAULT;
            end
            default: begin
                state_nxt = ST_FETCH;
            end
        endcase
        // Every retiring path funnels through here so the halt decision lives in one place.
        if (retire_c) state_nxt = (halt_pending || halt_req) ? ST_HALT : ST_FETCH;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_FETCH;
            halt_pending <= 1'b0;
            wd_cnt       <= '0;
            cause_q      <= 2'b00;
            count_q      <= '0;
        end else begin
            state <= state_nxt;
            if (retire_c) count_q <= count_q + RETIRE_CNT_WIDTH'(1);
            if ((state_nxt == ST_FAULT) && (state != ST_FAULT)) cause_q <= cause_nxt;
            if ((state_nxt == ST_HALT) && (state != ST_HALT))
                halt_pending <= 1'b0;
            else if (halt_req && !retire_c && (state != ST_HALT) && (state != ST_FAULT))
                halt_pending <= 1'b1;
            // Stall counter only runs while a memory access is outstanding in the same state.
            if ((MEM_TIMEOUT > 0) && mem_wait && (state_nxt == state))
                wd_cnt <= wd_cnt + WD_W'(1);
            else
                wd_cnt <= '0;
        end
    end

    // Outputs are forced low while reset is held, even though FETCH would otherwise request memory.
    assign stage         = STAGE_WIDTH'(state);
    assign ir_en         = ir_en_c   & rst;
    assign pc_en         = pc_en_c   & rst;
    assign rf_we         = rf_we_c   & rst;
    assign mem_req       = mem_req_c & rst;
    assign mem_we        = mem_we_c  & rst;
    assign retire        = retire_c  & rst;
    assign halted        = (state == ST_HALT)  & rst;
    assign fault         = (state == ST_FAULT) & rst;
    assign fault_cause   = cause_q;
    assign retired_count = count_q;

endmodule

// File: tb/tb_multi_cycle_sequencer.sv
// Directed bench for multi_cycle_sequencer built with MEM_TIMEOUT=4 and a 4-bit retire counter.
module tb_multi_cycle_sequencer;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       halt_req;
    logic       resume;
    logic [2:0] stage;
    logic       ir_en, pc_en, rf_we, mem_req, mem_we, retire, halted, fault;
    logic [3:0] retired_count;
    logic [1:0] fault_cause;
    logic [7:0] ctl;

    int total = 0;
    int bad   = 0;

    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;
    localparam logic [6:0] BEQ   = 7'b1100011;
    localparam logic [6:0] OP    = 7'b0110011;
    localparam logic [6:0] ADDI  = 7'b0010011;
    localparam logic [6:0] ILL   = 7'b1111111;

    multi_cycle_sequencer #(
        .STAGE_WIDTH(3),
        .RETIRE_CNT_WIDTH(4),
        .MEM_TIMEOUT(4)
    ) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .halt_req(halt_req), .resume(resume), .stage(stage),
        .ir_en(ir_en), .pc_en(pc_en), .rf_we(rf_we), .mem_req(mem_req),
        .mem_we(mem_we), .retire(retire), .retired_count(retired_count),
        .halted(halted), .fault(fault), .fault_cause(fault_cause)
    );

    // {ir_en, pc_en, rf_we, mem_req, mem_we, retire, halted, fault}
    assign ctl = {ir_en, pc_en, rf_we, mem_req, mem_we, retire, halted, fault};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b0; mem_ready = 1'b0; halt_req = 1'b0; resume = 1'b0; opcode = ADDI;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b0; mem_ready = 1'b1; halt_req = 1'b0; resume = 1'b0; opcode = ADDI;
        #2;
        total++;
        if ({stage, ctl, retired_count, fault_cause} !== {3'd0, 8'h00, 4'd0, 2'b00}) begin
            bad++;
            $display("FAIL reset_state got st=%0d ctl=%02h cnt=%0d cause=%0d exp st=0 ctl=00 cnt=0 cause=0",
                     stage, ctl, retired_count, fault_cause);
        end
        tick();
        rst = 1'b1;
    endtask

    task automatic test_addi;
        logic [2:0] es [0:3];
        logic [7:0] ec [0:3];
        es = '{3'd0, 3'd1, 3'd2, 3'd4};
        ec = '{8'h90, 8'h00, 8'h00, 8'h64};
        do_reset();
        opcode = ADDI; mem_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            total++;
            if ({stage, ctl} !== {es[i%4], ec[i%4]}) begin
                bad++;
                $display("FAIL addi cyc%0d got st=%0d ctl=%02h exp st=%0d ctl=%02h", i, stage, ctl, es[i%4], ec[i%4]);
            end
            tick();
        end
        total++;
        if (retired_count !== 4'd3) begin
            bad++;
            $display("FAIL addi_count got=%0d exp=3", retired_count);
        end
    endtask

    task automatic test_load;
        logic [2:0] es [0:6];
        logic [7:0] ec [0:6];
        logic       rdy [0:6];
        es  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4};
        ec  = '{8'h90, 8'h00, 8'h00, 8'h10, 8'h10, 8'h10, 8'h64};
        rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        opcode = LOAD;
        for (int i = 0; i < 7; i++) begin
            mem_ready = rdy[i];
            @(negedge clk);
            total++;
            if ({stage, ctl} !== {es[i], ec[i]}) begin
                bad++;
                $display("FAIL load cyc%0d got st=%0d ctl=%02h exp st=%0d ctl=%02h", i, stage, ctl, es[i], ec[i]);
            end
            tick();
        end
        total++;
        if ({stage, retired_count} !== {3'd0, 4'd1}) begin
            bad++;
            $display("FAIL load_end got st=%0d cnt=%0d exp st=0 cnt=1", stage, retired_count);
        end
    endtask

    task automatic test_store_branch;
        logic [2:0] es [0:6];
        logic [7:0] ec [0:6];
        es = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2};
        ec = '{8'h90, 8'h00, 8'h00, 8'h5C, 8'h90, 8'h00, 8'h44};
        do_reset();
        mem_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            opcode = (i < 4) ? STORE : BEQ;
            @(negedge clk);
            total++;
            if ({stage, ctl} !== {es[i], ec[i]}) begin
                bad++;
                $display("FAIL store_beq cyc%0d got st=%0d ctl=%02h exp st=%0d ctl=%02h", i, stage, ctl, es[i], ec[i]);
            end
            tick();
        end
        total++;
        if ({stage, retired_count} !== {3'd0, 4'd2}) begin
            bad++;
            $display("FAIL store_beq_end got st=%0d cnt=%0d exp st=0 cnt=2", stage, retired_count);
        end
    endtask

    task automatic test_halt;
        logic [2:0] es [0:4];
        logic [7:0] ec [0:4];
        es = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd6};
        ec = '{8'h90, 8'h00, 8'h00, 8'h64, 8'h02};
        do_reset();
        opcode = OP; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            halt_req = (i == 1);
            @(negedge clk);
            total++;
            if ({stage, ctl} !== {es[i], ec[i]}) begin
                bad++;
                $display("FAIL halt cyc%0d got st=%0d ctl=%02h exp st=%0d ctl=%02h", i, stage, ctl, es[i], ec[i]);
            end
            tick();
        end
        // Still halted after one idle cycle, then resume blocked by a concurrent halt_req.
        total++;
        if ({stage, halted} !== {3'd6, 1'b1}) begin
            bad++;
            $display("FAIL halt_idle got st=%0d halted=%0b exp st=6 halted=1", stage, halted);
        end
        resume = 1'b1; halt_req = 1'b1;
        tick();
        total++;
        if ({stage, halted} !== {3'd6, 1'b1}) begin
            bad++;
            $display("FAIL halt_resume_blocked got st=%0d halted=%0b exp st=6 halted=1", stage, halted);
        end
        halt_req = 1'b0;
        tick();
        resume = 1'b0;
        @(negedge clk);
        total++;
        if ({stage, ctl, retired_count} !== {3'd0, 8'h90, 4'd1}) begin
            bad++;
            $display("FAIL halt_resume got st=%0d ctl=%02h cnt=%0d exp st=0 ctl=90 cnt=1", stage, ctl, retired_count);
        end
    endtask

    task automatic test_timeout;
        do_reset();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        total++;
        if ({stage, fault} !== {3'd0, 1'b0}) begin
            bad++;
            $display("FAIL timeout_early got st=%0d fault=%0b exp st=0 fault=0", stage, fault);
        end
        tick();
        total++;
        if ({stage, fault, fault_cause, ctl} !== {3'd7, 1'b1, 2'b01, 8'h01}) begin
            bad++;
            $display("FAIL timeout_fault got st=%0d fault=%0b cause=%0d ctl=%02h exp st=7 fault=1 cause=1 ctl=01",
                     stage, fault, fault_cause, ctl);
        end
        mem_ready = 1'b1; resume = 1'b1;
        tick();
        tick();
        resume = 1'b0;
        total++;
        if ({stage, fault, fault_cause, retired_count} !== {3'd7, 1'b1, 2'b01, 4'd0}) begin
            bad++;
            $display("FAIL timeout_sticky got st=%0d fault=%0b cause=%0d cnt=%0d exp st=7 fault=1 cause=1 cnt=0",
                     stage, fault, fault_cause, retired_count);
        end
        rst = 1'b0;
        #1;
        total++;
        if ({stage, fault, fault_cause} !== {3'd0, 1'b0, 2'b00}) begin
            bad++;
            $display("FAIL timeout_clear got st=%0d fault=%0b cause=%0d exp st=0 fault=0 cause=0", stage, fault, fault_cause);
        end
        tick();
        rst = 1'b1;
    endtask

    task automatic test_timeout_edge;
        do_reset();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        mem_ready = 1'b1;
        @(negedge clk);
        total++;
        if ({stage, ctl} !== {3'd0, 8'h90}) begin
            bad++;
            $display("FAIL timeout_edge got st=%0d ctl=%02h exp st=0 ctl=90", stage, ctl);
        end
        tick();
        total++;
        if ({stage, fault} !== {3'd1, 1'b0}) begin
            bad++;
            $display("FAIL timeout_edge_next got st=%0d fault=%0b exp st=1 fault=0", stage, fault);
        end
    endtask

    task automatic test_illegal;
        do_reset();
        opcode = ILL; mem_ready = 1'b1;
        tick();
        total++;
        if (stage !== 3'd1) begin
            bad++;
            $display("FAIL illegal_decode got st=%0d exp st=1", stage);
        end
        tick();
        total++;
        if ({stage, fault, fault_cause} !== {3'd7, 1'b1, 2'b10}) begin
            bad++;
            $display("FAIL illegal_fault got st=%0d fault=%0b cause=%0d exp st=7 fault=1 cause=2", stage, fault, fault_cause);
        end
    endtask

    task automatic test_wrap;
        do_reset();
        opcode = ADDI; mem_ready = 1'b1;
        for (int i = 0; i < 60; i++) tick();
        total++;
        if (retired_count !== 4'd15) begin
            bad++;
            $display("FAIL wrap_15 got=%0d exp=15", retired_count);
        end
        for (int i = 0; i < 4; i++) tick();
        total++;
        if ({stage, retired_count} !== {3'd0, 4'd0}) begin
            bad++;
            $display("FAIL wrap_0 got st=%0d cnt=%0d exp st=0 cnt=0", stage, retired_count);
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        opcode = ADDI; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        opcode = STORE;
        for (int i = 0; i < 3; i++) tick();
        @(negedge clk);
        total++;
        if ({stage, ctl, retired_count} !== {3'd3, 8'h5C, 4'd1}) begin
            bad++;
            $display("FAIL mid_pre got st=%0d ctl=%02h cnt=%0d exp st=3 ctl=5c cnt=1", stage, ctl, retired_count);
        end
        rst = 1'b0;
        #1;
        total++;
        if ({stage, ctl, retired_count} !== {3'd0, 8'h00, 4'd0}) begin
            bad++;
            $display("FAIL mid_reset got st=%0d ctl=%02h cnt=%0d exp st=0 ctl=00 cnt=0", stage, ctl, retired_count);
        end
        tick();
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load();
        test_store_branch();
        test_halt();
        test_timeout();
        test_timeout_edge();
        test_illegal();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
